lc3b_local_predictor: RTL and testbench

- Parametrised two-level local-history branch predictor for the LC-3b fetch stage. Generalises the fixed local BHT index widths (6-bit history-table index, 10-bit pattern index) to configurable table sizes, history length and counter width.
- Fetch issues a PC and gets a registered taken/not-taken prediction plus a history snapshot. The snapshot travels down the pipeline and is returned with the resolved outcome to train the tables.
- After reset, a self-clearing init sweep runs before the predictor reports ready.

---
 rtl/lc3b_local_predictor.sv | 171 +++++++++++++++++
 tb/tb_lc3b_local_predictor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_local_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lc3b_local_predictor : two-level local-history branch predictor (LHT + PHT)
// Revision: 1.0
// ============================================================================
module lc3b_local_predictor #(
  parameter int PC_LSB       = 1,
  parameter int LHT_IDX_BITS = 6,
  parameter int HIST_BITS    = 4,
  parameter int PHT_PC_BITS  = 6,
  parameter int CTR_BITS     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  input  logic                 pred_valid,
  input  logic [15:0]          pred_pc,
  output logic                 resp_valid,
  output logic                 resp_taken,
  output logic [HIST_BITS-1:0] resp_hist,
  input  logic                 update_valid,
  input  logic [15:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken,
  input  logic                 update_mispredict,
  output logic [15:0]          mispredict_count
);

  localparam int PHT_IDX_BITS = PHT_PC_BITS + HIST_BITS;
  localparam int SWEEP_BITS   = (LHT_IDX_BITS > PHT_IDX_BITS) ? LHT_IDX_BITS : PHT_IDX_BITS;
  localparam int LHT_DEPTH    = 1 << LHT_IDX_BITS;
  localparam int PHT_DEPTH    = 1 << PHT_IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [SWEEP_BITS-1:0]   sweep_q, sweep_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_taken_q, resp_taken_d;
  logic [HIST_BITS-1:0]    resp_hist_q, resp_hist_d;
  logic [15:0]             mcount_q, mcount_d;

  logic [HIST_BITS-1:0]    lht_mem [LHT_DEPTH];
  logic [CTR_BITS-1:0]     pht_mem [PHT_DEPTH];

  logic [LHT_IDX_BITS-1:0] pred_lht_idx, upd_lht_idx;
  logic [PHT_IDX_BITS-1:0] pred_pht_idx, upd_pht_idx;
  logic [HIST_BITS-1:0]    pred_hist, upd_lht_old;
  logic [CTR_BITS-1:0]     pred_ctr, upd_ctr;

  logic                    lht_we, pht_we;
  logic [LHT_IDX_BITS-1:0] lht_waddr;
  logic [PHT_IDX_BITS-1:0] pht_waddr;
  logic [HIST_BITS-1:0]    lht_wdata;
  logic [CTR_BITS-1:0]     pht_wdata;
  logic                    sweep_in_lht, sweep_in_pht;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc, update_pc};

  assign pred_lht_idx = pred_pc[PC_LSB +: LHT_IDX_BITS];
  assign pred_hist    = lht_mem[pred_lht_idx];
  assign pred_pht_idx = {pred_pc[PC_LSB +: PHT_PC_BITS], pred_hist};
  assign pred_ctr     = pht_mem[pred_pht_idx];

  // Training indexes the PHT with the returned snapshot, but shifts the live LHT entry.
  assign upd_lht_idx  = update_pc[PC_LSB +: LHT_IDX_BITS];
  assign upd_lht_old  = lht_mem[upd_lht_idx];
  assign upd_pht_idx  = {update_pc[PC_LSB +: PHT_PC_BITS], update_hist};
  assign upd_ctr      = pht_mem[upd_pht_idx];

  assign sweep_in_lht = ((sweep_q >> LHT_IDX_BITS) == '0);
  assign sweep_in_pht = ((sweep_q >> PHT_IDX_BITS) == '0);

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    resp_valid_d = 1'b0;
    resp_taken_d = resp_taken_q;
    resp_hist_d  = resp_hist_q;
    mcount_d     = mcount_q;
    lht_we       = 1'b0;
    lht_waddr    = '0;
    lht_wdata    = '0;
    pht_we       = 1'b0;
    pht_waddr    = '0;
    pht_wdata    = '0;

    case (state_q)
      ST_INIT: begin
        sweep_d   = sweep_q + SWEEP_BITS'(1);
        lht_we    = sweep_in_lht;
        lht_waddr = sweep_q[LHT_IDX_BITS-1:0];
        lht_wdata = '0;
        pht_we    = sweep_in_pht;
        pht_waddr = sweep_q[PHT_IDX_BITS-1:0];
        pht_wdata = CTR_WNT;
        if (&sweep_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pred_valid) begin
          resp_valid_d = 1'b1;
          resp_taken_d = pred_ctr[CTR_BITS-1];
          resp_hist_d  = pred_hist;
        end
        if (update_valid) begin
          lht_we    = 1'b1;
          lht_waddr = upd_lht_idx;
          lht_wdata = {upd_lht_old[HIST_BITS-2:0], update_taken};
          pht_we    = 1'b1;
          pht_waddr = upd_pht_idx;
          if (update_taken) begin
            pht_wdata = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + CTR_BITS'(1);
          end else begin
            pht_wdata = (upd_ctr == '0) ? upd_ctr : upd_ctr - CTR_BITS'(1);
          end
          if (update_mispredict && (mcount_q != 16'hFFFF)) begin
            mcount_d = mcount_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_hist_q  <= '0;
      mcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_hist_q  <= resp_hist_d;
      mcount_q     <= mcount_d;
    end
  end

  // Table storage has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (lht_we) begin
      lht_mem[lht_waddr] <= lht_wdata;
    end
    if (pht_we) begin
      pht_mem[pht_waddr] <= pht_wdata;
    end
  end

  assign ready            = (state_q == ST_RUN);
  assign resp_valid       = resp_valid_q;
  assign resp_taken       = resp_taken_q;
  assign resp_hist        = resp_hist_q;
  assign mispredict_count = mcount_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_local_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for lc3b_local_predictor: random and directed traffic scored against a table-level model.
module tb_lc3b_local_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready;
  logic        pred_valid = 1'b0;
  logic [15:0] pred_pc = '0;
  logic        resp_valid;
  logic        resp_taken;
  logic [3:0]  resp_hist;
  logic        update_valid = 1'b0;
  logic [15:0] update_pc = '0;
  logic [3:0]  update_hist = '0;
  logic        update_taken = 1'b0;
  logic        update_mispredict = 1'b0;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  lc3b_local_predictor dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ready             (ready),
    .pred_valid        (pred_valid),
    .pred_pc           (pred_pc),
    .resp_valid        (resp_valid),
    .resp_taken        (resp_taken),
    .resp_hist         (resp_hist),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_hist       (update_hist),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .mispredict_count  (mispredict_count)
  );

  typedef struct {
    int       due;
    bit       taken;
    bit [3:0] hist;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: history per LHT slot, counter value 0..3 per PHT slot.
  int lht_m [64];
  int pht_m [1024];
  int mcount_m;
  bit run_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lidx(input logic [15:0] pc);
    return int'(pc >> 1) & 63;
  endfunction

  function automatic int pidx(input logic [15:0] pc, input int h);
    return ((int'(pc >> 1) & 63) << 4) | h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) lht_m[i] = 0;
    for (int i = 0; i < 1024; i++) pht_m[i] = 1;
    mcount_m = 0;
  endtask

  // Monitor: every cycle either a response is due or resp_valid must be low.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("resp_valid", int'(resp_valid), 1);
        check("resp_taken", int'(resp_taken), int'(e.taken));
        check("resp_hist", int'(resp_hist), int'(e.hist));
      end else begin
        check("resp_valid_idle", int'(resp_valid), 0);
      end
    end
  end

  task automatic step(input bit pv, input logic [15:0] ppc, input bit uv,
                      input logic [15:0] upc, input logic [3:0] uh,
                      input bit ut, input bit um);
    int h, p, l;
    exp_t e;
    @(posedge clk);
    #2;
    pred_valid = pv; pred_pc = ppc;
    update_valid = uv; update_pc = upc; update_hist = uh;
    update_taken = ut; update_mispredict = um;
    if (run_m) begin
      if (pv) begin
        h = lht_m[lidx(ppc)];
        e.due = cyc + 1;
        e.taken = (pht_m[pidx(ppc, h)] >= 2);
        e.hist = 4'(h);
        sb.push_back(e);
      end
      if (uv) begin
        p = pidx(upc, int'(uh));
        if (ut) pht_m[p] = (pht_m[p] == 3) ? 3 : pht_m[p] + 1;
        else    pht_m[p] = (pht_m[p] == 0) ? 0 : pht_m[p] - 1;
        l = lidx(upc);
        lht_m[l] = ((lht_m[l] << 1) | int'(ut)) & 15;
        if (um && mcount_m < 65535) mcount_m++;
      end
    end
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  task automatic idle();
    step(1'b0, rnd16(), 1'b0, rnd16(), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic do_pred(input logic [15:0] pc);
    step(1'b1, pc, 1'b0, rnd16(), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic do_upd(input logic [15:0] pc, input int h, input bit t, input bit m);
    step(1'b0, rnd16(), 1'b1, pc, 4'(h), t, m);
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    pred_valid = 1'b0;
    update_valid = 1'b0;
    sb.delete();
    run_m = 1'b0;
    model_reset();
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_taken", int'(resp_taken), 0);
    check("rst_resp_hist", int'(resp_hist), 0);
    check("rst_mcount", int'(mispredict_count), 0);
  endtask

  // Releases reset and counts edges until ready; requests made during the sweep must be ignored.
  task automatic release_and_sweep(input int stop_after);
    int n;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pred_valid = 1'b1; pred_pc = rnd16();
    update_valid = 1'b1; update_pc = rnd16(); update_hist = 4'($urandom);
    update_taken = 1'b1; update_mispredict = 1'b1;
    n = 0;
    while (!ready && n < 2000 && (stop_after == 0 || n < stop_after)) begin
      @(posedge clk);
      #1;
      n++;
    end
    pred_valid = 1'b0;
    update_valid = 1'b0;
    if (stop_after == 0) begin
      check("sweep_len", n, 1024);
      check("post_sweep_mcount", int'(mispredict_count), 0);
      run_m = 1'b1;
    end else begin
      check("ready_mid_sweep", int'(ready), 0);
    end
  endtask

  function automatic logic [15:0] pick_pc();
    return 16'(($urandom_range(0, 3) << 1) | ($urandom_range(0, 1) << 6) |
               ($urandom_range(0, 1) << 9));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int uh;
    model_reset();
    repeat (2) @(posedge clk);
    assert_reset();
    release_and_sweep(0);

    // Defaults and always-taken training at 0x0040.
    do_pred(16'h0040);
    for (int k = 0; k < 5; k++) begin
      do_pred(16'h0040);
      do_upd(16'h0040, lht_m[lidx(16'h0040)], 1'b1, 1'b0);
    end
    do_pred(16'h0040);
    for (int k = 0; k < 4; k++) do_upd(16'h0040, 15, 1'b1, 1'b0);
    do_upd(16'h0040, 15, 1'b0, 1'b0);
    do_pred(16'h0040);

    // Same-cycle predict and update on the same entry.
    step(1'b1, 16'h0040, 1'b1, 16'h0040, 4'(lht_m[lidx(16'h0040)]), 1'b1, 1'b0);
    do_pred(16'h0040);

    // LHT aliasing between 0x00C0 and 0x0040; 0x0042 is a separate slot.
    do_upd(16'h00C0, 3, 1'b1, 1'b0);
    do_upd(16'h00C0, 5, 1'b0, 1'b0);
    do_pred(16'h0040);
    do_pred(16'h0042);
    idle();

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] upc;
      upc = pick_pc();
      uh = ($urandom_range(0, 1) == 1) ? lht_m[lidx(upc)] : int'($urandom_range(0, 15));
      step(1'($urandom), pick_pc(), 1'($urandom), upc, 4'(uh), 1'($urandom),
           ($urandom_range(0, 3) == 0));
    end
    idle();
    #1;
    check("mcount_random", int'(mispredict_count), mcount_m);

    // Mid-RUN reset with a non-zero count, then a reset inside the sweep.
    assert_reset();
    release_and_sweep(0);
    for (int k = 0; k < 5; k++) do_upd(pick_pc(), int'($urandom_range(0, 15)), 1'($urandom), 1'b1);
    idle();
    #1;
    check("mcount_five", int'(mispredict_count), 5);
    assert_reset();
    release_and_sweep(300);
    assert_reset();
    release_and_sweep(0);
    do_pred(16'h0040);

    for (int i = 0; i < 70000; i++) begin
      do_upd(pick_pc(), int'($urandom_range(0, 15)), 1'($urandom), 1'b1);
    end
    idle();
    #1;
    check("mcount_sat", int'(mispredict_count), mcount_m);
    check("mcount_sat_const", int'(mispredict_count), 65535);
    do_pred(16'h0042);
    repeat (3) idle();
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
